// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings and output decode for the MIPS-Lite multicycle controller
//   state_t  : FSM states, 4-bit, exposed on the State debug port
//   cls_t    : instruction class produced by instr_decode
//   ctrl_t   : bundle of datapath control outputs
//   ctrl_of  : Moore output table (state + class -> controls)
package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_R, S_WB_R, S_EXE_I, S_WB_I,
    S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} cls_t;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] MR_ALU = 2'b00;
  localparam logic [1:0] MR_MEM = 2'b01;
  localparam logic [1:0] MR_PC  = 2'b10;
  localparam logic [1:0] SB_RT   = 2'b00;
  localparam logic [1:0] SB_4    = 2'b01;
  localparam logic [1:0] SB_SEXT = 2'b10;
  localparam logic [1:0] SB_ZEXT = 2'b11;
  typedef struct packed {
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       irwr;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       dmrd;
    logic       dmwr;
  } ctrl_t;
  // PCWr in BRANCH depends on Zero and is added by the top level.
  function automatic ctrl_t ctrl_of(state_t s, cls_t c, logic [2:0] alu);
    ctrl_t k;
    k = '0;
    case (s)
      S_FETCH:   begin k.irwr = 1'b1; k.pcwr = 1'b1; k.pcsrc = PC_INC; end
      S_EXE_R:   begin k.alusrcb = SB_RT; k.aluop = alu; end
      S_WB_R:    begin k.regwrite = 1'b1; k.regdst = RD_RD; k.memtoreg = MR_ALU; end
      S_EXE_I:   begin k.alusrcb = SB_ZEXT; k.aluop = alu; end
      S_WB_I:    begin k.regwrite = 1'b1; k.regdst = RD_RT; k.memtoreg = MR_ALU; end
      S_MEM_ADR: begin k.alusrcb = SB_SEXT; k.aluop = ALU_ADD; end
      S_MEM_RD:  k.dmrd = 1'b1;
      S_MEM_WR:  k.dmwr = 1'b1;
      S_WB_MEM:  begin k.regwrite = 1'b1; k.regdst = RD_RT; k.memtoreg = MR_MEM; end
      S_BRANCH:  begin k.alusrcb = SB_RT; k.aluop = ALU_SUB; k.pcsrc = PC_BR; end
      S_JUMP: begin
        k.pcwr = 1'b1;
        k.pcsrc = PC_JMP;
        if (c == C_JAL) begin
          k.regwrite = 1'b1;
          k.regdst = RD_RA;
          k.memtoreg = MR_PC;
        end
      end
      default: ;
    endcase
    return k;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// instr_decode: combinational opcode/funct classifier
//   op, funct : IR[31:26], IR[5:0]
//   cls       : instruction class (C_ILL for anything unsupported)
//   alu_op    : ALU operation used in the execute state
//   legal     : 1 when the instruction is supported
module instr_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] alu_op,
  output logic       legal
);
  always_comb begin
    cls = C_ILL;
    alu_op = ALU_ADD;
    case (op)
      OP_R: case (funct)
        F_ADDU: cls = C_R;
        F_SUBU: begin cls = C_R; alu_op = ALU_SUB; end
        F_SLT:  begin cls = C_R; alu_op = ALU_SLT; end
        default: ;
      endcase
      OP_ORI: begin cls = C_I; alu_op = ALU_OR; end
      OP_LUI: begin cls = C_I; alu_op = ALU_LUI; end
      OP_LW:  cls = C_LW;
      OP_SW:  cls = C_SW;
      OP_BEQ: begin cls = C_BEQ; alu_op = ALU_SUB; end
      OP_J:   cls = C_J;
      OP_JAL: cls = C_JAL;
      default: ;
    endcase
  end
  assign legal = cls != C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore multicycle control FSM for the MIPS-Lite datapath
//   Clk, Reset (async, active low), Op/Funct from IR, Zero from ALU, DmReady from data memory
//   PCWr/PCSrc, IRWr, Regwrite/RegDst/MemtoReg, ALUSrcB/ALUOp, DmRd/DmWr : datapath controls
//   State (debug), InstrCnt (retired count), Illegal and BusErr (sticky flags)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             DmReady,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             IRWr,
  output logic             Regwrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             DmRd,
  output logic             DmWr,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCnt,
  output logic             Illegal,
  output logic             BusErr
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t st, nxt;
  cls_t cls;
  logic [2:0] alu_op;
  logic legal, mem_wait, timed_out, retire;
  logic [WW-1:0] wait_cnt;
  ctrl_t ctl;
  instr_decode u_dec (.op(Op), .funct(Funct), .cls(cls), .alu_op(alu_op), .legal(legal));
  assign mem_wait = (st == S_MEM_RD || st == S_MEM_WR) && !DmReady;
  // This zero-ready cycle is the TIMEOUT-th one, so the request drops after it.
  assign timed_out = mem_wait && wait_cnt == WW'(TIMEOUT - 1);
  assign retire = st == S_WB_R || st == S_WB_I || st == S_WB_MEM || st == S_BRANCH ||
                  st == S_JUMP || (st == S_MEM_WR && DmReady);
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:   nxt = S_DECODE;
      S_DECODE:  nxt = cls == C_R ? S_EXE_R :
                       cls == C_I ? S_EXE_I :
                       (cls == C_LW || cls == C_SW) ? S_MEM_ADR :
                       cls == C_BEQ ? S_BRANCH :
                       (cls == C_J || cls == C_JAL) ? S_JUMP : S_FETCH;
      S_EXE_R:   nxt = S_WB_R;
      S_EXE_I:   nxt = S_WB_I;
      S_MEM_ADR: nxt = cls == C_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  nxt = DmReady ? S_WB_MEM : timed_out ? S_FETCH : S_MEM_RD;
      S_MEM_WR:  nxt = (DmReady || timed_out) ? S_FETCH : S_MEM_WR;
      default:   nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st <= S_FETCH;
      wait_cnt <= '0;
      InstrCnt <= '0;
      Illegal <= 1'b0;
      BusErr <= 1'b0;
    end else begin
      st <= nxt;
      wait_cnt <= st == S_MEM_ADR ? '0 : mem_wait ? wait_cnt + WW'(1) : wait_cnt;
      InstrCnt <= InstrCnt + CNT_W'(retire);
      Illegal <= Illegal | (st == S_DECODE && !legal);
      BusErr <= BusErr | timed_out;
    end
  end
  // Gating with Reset makes every control drop the instant reset asserts.
  assign ctl = Reset ? ctrl_of(st, cls, alu_op) : '0;
  assign PCWr = ctl.pcwr | (Reset && st == S_BRANCH && Zero);
  assign PCSrc = ctl.pcsrc;
  assign IRWr = ctl.irwr;
  assign Regwrite = ctl.regwrite;
  assign RegDst = ctl.regdst;
  assign MemtoReg = ctl.memtoreg;
  assign ALUSrcB = ctl.alusrcb;
  assign ALUOp = ctl.aluop;
  assign DmRd = ctl.dmrd;
  assign DmWr = ctl.dmwr;
  assign State = st;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench with a per-cycle instruction-level model of the controller
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;
  localparam int TO = 16;
  logic Clk = 1'b0, Reset = 1'b0, Zero = 1'b0, DmReady = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic PCWr, IRWr, Regwrite, DmRd, DmWr, Illegal, BusErr;
  logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic [31:0] InstrCnt;
  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .DmReady(DmReady),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .Regwrite(Regwrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .DmRd(DmRd), .DmWr(DmWr),
    .State(State), .InstrCnt(InstrCnt), .Illegal(Illegal), .BusErr(BusErr)
  );
  always #5 Clk = ~Clk;
  typedef struct packed {
    logic [3:0]  st;
    logic        pcwr;
    logic [1:0]  pcsrc;
    logic        irwr;
    logic        rw;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic [1:0]  srcb;
    logic [2:0]  aluop;
    logic        dmrd;
    logic        dmwr;
    logic [31:0] cnt;
    logic        ill;
    logic        berr;
  } exp_t;
  exp_t cur;
  logic chk = 1'b0;
  int checks = 0, failures = 0;
  int m_cnt = 0;
  logic m_ill = 1'b0, m_berr = 1'b0;
  int dmrd_hi = 0, dmwr_hi = 0, rw_hi = 0, ncyc = 0;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, x, $time);
    end
  endtask
  // Expected controls for one cycle spent in state s, from the state/output table.
  function automatic exp_t ex(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    e.cnt = m_cnt;
    e.ill = m_ill;
    e.berr = m_berr;
    if (s == S_FETCH) begin e.irwr = 1; e.pcwr = 1; end
    if (s == S_EXE_R) e.aluop = Funct == 6'h23 ? 3'd1 : Funct == 6'h2a ? 3'd3 : 3'd0;
    if (s == S_WB_R) begin e.rw = 1; e.regdst = 2'd1; end
    if (s == S_EXE_I) begin e.srcb = 2'd3; e.aluop = Op == 6'h0f ? 3'd4 : 3'd2; end
    if (s == S_WB_I) e.rw = 1;
    if (s == S_MEM_ADR) e.srcb = 2'd2;
    if (s == S_MEM_RD) e.dmrd = 1;
    if (s == S_MEM_WR) e.dmwr = 1;
    if (s == S_WB_MEM) begin e.rw = 1; e.memtoreg = 2'd1; end
    if (s == S_BRANCH) begin e.aluop = 3'd1; e.pcsrc = 2'd1; e.pcwr = Zero; end
    if (s == S_JUMP) begin
      e.pcwr = 1;
      e.pcsrc = 2'd2;
      if (Op == 6'h03) begin e.rw = 1; e.regdst = 2'd2; e.memtoreg = 2'd2; end
    end
    return e;
  endfunction
  task automatic cyc(input logic [3:0] s, input logic rdy);
    DmReady = rdy;
    cur = ex(s);
    chk = 1'b1;
    ncyc++;
    @(posedge Clk);
    #1;
  endtask
  // Runs one instruction; w is the number of DmReady=0 cycles before ready.
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int w);
    logic is_r;
    Op = o;
    Funct = f;
    Zero = z;
    ncyc = 0;
    is_r = o == 6'h00 && (f == 6'h21 || f == 6'h23 || f == 6'h2a);
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    if (is_r) begin
      cyc(S_EXE_R, 0); cyc(S_WB_R, 0); m_cnt++;
    end else if (o == 6'h0d || o == 6'h0f) begin
      cyc(S_EXE_I, 0); cyc(S_WB_I, 0); m_cnt++;
    end else if (o == 6'h23 || o == 6'h2b) begin
      cyc(S_MEM_ADR, 0);
      for (int i = 0; i < w && i < TO; i++) cyc(o == 6'h23 ? S_MEM_RD : S_MEM_WR, 0);
      if (w >= TO) m_berr = 1'b1;
      else begin
        cyc(o == 6'h23 ? S_MEM_RD : S_MEM_WR, 1);
        if (o == 6'h23) cyc(S_WB_MEM, 0);
        m_cnt++;
      end
    end else if (o == 6'h04) begin
      cyc(S_BRANCH, 0); m_cnt++;
    end else if (o == 6'h02 || o == 6'h03) begin
      cyc(S_JUMP, 0); m_cnt++;
    end else m_ill = 1'b1;
  endtask
  always @(negedge Clk) begin
    if (chk) begin
      check("state", State, cur.st);
      check("pcwr", PCWr, cur.pcwr);
      check("pcsrc", PCSrc, cur.pcsrc);
      check("irwr", IRWr, cur.irwr);
      check("regwrite", Regwrite, cur.rw);
      check("regdst", RegDst, cur.regdst);
      check("memtoreg", MemtoReg, cur.memtoreg);
      check("alusrcb", ALUSrcB, cur.srcb);
      check("aluop", ALUOp, cur.aluop);
      check("dmrd", DmRd, cur.dmrd);
      check("dmwr", DmWr, cur.dmwr);
      check("instrcnt", InstrCnt, cur.cnt);
      check("illegal", Illegal, cur.ill);
      check("buserr", BusErr, cur.berr);
      if (DmRd) dmrd_hi++;
      if (DmWr) dmwr_hi++;
      if (Regwrite) rw_hi++;
    end
  end
  initial begin
    int d0;
    #12;
    check("rst_state", State, S_FETCH);
    check("rst_irwr", IRWr, 0);
    check("rst_pcwr", PCWr, 0);
    check("rst_cnt", InstrCnt, 0);
    check("rst_flags", {Illegal, BusErr}, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    d0 = rw_hi;
    instr(6'h00, 6'h21, 0, 0);
    check("addu_cnt", InstrCnt, 1);
    check("addu_len", ncyc, 4);
    check("addu_rw_cycles", rw_hi - d0, 1);
    d0 = dmrd_hi;
    instr(6'h23, 6'h00, 0, 3);
    check("lw_len", ncyc, 8);
    check("lw_dmrd_cycles", dmrd_hi - d0, 4);
    check("lw_cnt", InstrCnt, 2);
    d0 = dmwr_hi;
    instr(6'h2b, 6'h00, 0, 16);
    check("sw_to_dmwr_cycles", dmwr_hi - d0, 16);
    check("sw_to_buserr", BusErr, 1);
    check("sw_to_state", State, S_FETCH);
    check("sw_to_cnt", InstrCnt, 2);
    instr(6'h04, 6'h00, 1, 0);
    check("beq1_len", ncyc, 3);
    instr(6'h04, 6'h00, 0, 0);
    check("beq0_cnt", InstrCnt, 4);
    d0 = rw_hi;
    instr(6'h03, 6'h00, 0, 0);
    check("jal_rw_cycles", rw_hi - d0, 1);
    check("jal_len", ncyc, 3);
    d0 = rw_hi;
    instr(6'h3f, 6'h00, 0, 0);
    check("ill_flag", Illegal, 1);
    check("ill_cnt", InstrCnt, 5);
    check("ill_rw_cycles", rw_hi - d0, 0);
    check("ill_state", State, S_FETCH);
    instr(6'h00, 6'h23, 0, 0);
    instr(6'h00, 6'h2a, 0, 0);
    instr(6'h0d, 6'h00, 0, 0);
    instr(6'h0f, 6'h00, 0, 0);
    instr(6'h23, 6'h00, 0, 0);
    instr(6'h2b, 6'h00, 0, 2);
    instr(6'h2b, 6'h00, 0, 15);
    instr(6'h02, 6'h00, 0, 0);
    instr(6'h00, 6'h20, 0, 0);
    check("mix_cnt", InstrCnt, 13);
    Op = 6'h00;
    Funct = 6'h21;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_EXE_R, 0);
    chk = 1'b0;
    #2;
    check("mid_wbr_rw", Regwrite, 1);
    Reset = 1'b0;
    #1;
    check("mid_rst_rw", Regwrite, 0);
    check("mid_rst_state", State, S_FETCH);
    check("mid_rst_cnt", InstrCnt, 0);
    check("mid_rst_flags", {Illegal, BusErr}, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    m_cnt = 0;
    m_ill = 1'b0;
    m_berr = 1'b0;
    instr(6'h00, 6'h21, 0, 0);
    check("post_rst_cnt", InstrCnt, 1);
    chk = 1'b0;
    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
